// File: rtl/ttm4_instruction_fetch.sv
// TTM4 fetch sequencer: owns PC, IR and the return-address stack, and fetches over req/ack.
// Optional build macro TTM4_FETCH_STEP_EN adds a STEP input that issues one instruction per pulse.
module ttm4_instruction_fetch #(
  parameter int ADDR_W    = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
`ifdef TTM4_FETCH_STEP_EN
  input  logic              STEP,
`endif
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA,
  output logic [4:0]        OP,
  output logic [2:0]        LR,
  output logic [2:0]        SR,
  output logic              IR_VALID,
  input  logic              nPC_LD,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  input  logic              nSK_EN,
  input  logic              SK_COND,
  input  logic              STK_EN,
  input  logic              SP_D_nU,
  output logic [ADDR_W-1:0] PC,
  output logic              STK_ERR,
  output logic              HALTED
);
  localparam int SP_W  = $clog2(STK_DEPTH + 1);
  localparam int IDX_W = $clog2(STK_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [10:0]       ir_q, ir_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stk_err_q, stk_err_d;
  logic [ADDR_W-1:0] stk_q [STK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STK_DEPTH];

  logic              fetch_ok;
  logic [ADDR_W-1:0] pc_inc1, pc_inc2;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic              unused_rdata;

`ifdef TTM4_FETCH_STEP_EN
  logic step_q, step_d;
  logic credit_q, credit_d;

  // A STEP edge arriving on the consuming ack cycle still leaves a fresh credit.
  always_comb begin
    step_d   = STEP;
    credit_d = credit_q;
    if (MEM_REQ && MEM_ACK) credit_d = 1'b0;
    if (STEP && !step_q)    credit_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      step_q   <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      credit_q <= credit_d;
    end
  end

  assign fetch_ok = credit_q;
`else
  assign fetch_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    stk_d     = stk_q;
    MEM_REQ   = 1'b0;
    IR_VALID  = 1'b0;
    pc_inc1   = pc_q + ADDR_W'(1);
    pc_inc2   = pc_q + ADDR_W'(2);
    sp_dec    = sp_q - SP_W'(1);
    push_idx  = sp_q[IDX_W-1:0];
    pop_idx   = sp_dec[IDX_W-1:0];

    case (state_q)
      S_FETCH: begin
        MEM_REQ = fetch_ok;
        if (fetch_ok && MEM_ACK) begin
          ir_d    = MEM_RDATA[15:5];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        IR_VALID = 1'b1;
        state_d  = S_FETCH;
        // Stack faults freeze the PC so the offending instruction address stays visible.
        if (STK_EN && SP_D_nU) begin
          if (sp_q == '0) begin
            stk_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            pc_d = stk_q[pop_idx];
            sp_d = sp_dec;
          end
        end else if (STK_EN) begin
          if (sp_q == SP_W'(STK_DEPTH)) begin
            stk_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            stk_d[push_idx] = pc_inc1;
            pc_d            = JUMP_ADDR;
            sp_d            = sp_q + SP_W'(1);
          end
        end else if (!nPC_LD) begin
          pc_d = JUMP_ADDR;
        end else if (!nSK_EN && SK_COND) begin
          pc_d = pc_inc2;
        end else begin
          pc_d = pc_inc1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      sp_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    stk_q <= stk_d;
  end

  assign MEM_ADDR     = pc_q;
  assign PC           = pc_q;
  assign OP           = ir_q[10:6];
  assign LR           = ir_q[5:3];
  assign SR           = ir_q[2:0];
  assign STK_ERR      = stk_err_q;
  assign HALTED       = (state_q == S_HALT);
  assign unused_rdata = ^MEM_RDATA[4:0];
endmodule
